// File: rtl/seg7_scan_rx.sv
// -----------------------------------------------------------------------------
// seg7_scan_rx
//
// Receive-side decoder for a multiplexed 7-segment display bus. The block
// samples the active-low segment lines and the one-hot digit select. It waits
// for each digit pattern to hold stable, then maps the glyph back to a hex
// nibble. One word is assembled per complete scan and offered on a
// valid/ready port.
//
// Build option:
//   SEG7_SCAN_RX_SYNC_EN  defined    : two-flop synchronizer on every input pin
//                                      (use when the bus is asynchronous).
//                         undefined  : a single input register (same-clock
//                                      source or simulation). Every latency is
//                                      one cycle shorter.
//
// Parameters:
//   NUM_DIGITS     digits per scan; the word is 4*NUM_DIGITS bits wide.
//   STABLE_CYCLES  identical synchronized samples needed to accept a digit
//                  (legal range 2..255).
//
// Ports:
//   clk         sole clock
//   rst         synchronous active-high reset
//   seg_in      {g,f,e,d,c,b,a}, active-low
//   digit_sel   one-hot digit strobe; bit i means digit i is driven
//   word_out    assembled word; nibble i holds digit i
//   digit_err   per-digit flag; the accepted glyph was illegal
//   word_valid  word_out/digit_err hold a word that has not yet been taken
//   word_ready  downstream takes the word
//   overrun     one-cycle pulse; a complete scan was dropped
// -----------------------------------------------------------------------------
module seg7_scan_rx #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    overrun
);

    localparam int         SW         = 7 + NUM_DIGITS;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    // The counter becomes STABLE_CYCLES-1 on the edge where it currently
    // reads STABLE_CYCLES-2 and the sample still matches.
    localparam logic [7:0] ACCEPT_AT  = 8'(STABLE_CYCLES - 2);

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // ---------------------------------------------------------------- input
    logic [SW-1:0] sync_reg;

`ifdef SEG7_SCAN_RX_SYNC_EN
    logic [SW-1:0] meta_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= {seg_in, digit_sel};
            sync_reg <= meta_reg;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {seg_in, digit_sel};
        end
    end
`endif

    logic [SW-1:0] prev_reg;
    logic [7:0]    cnt_reg;
    logic          same;

    assign same = (sync_reg == prev_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            prev_reg <= sync_reg;
            if (!same) begin
                cnt_reg <= '0;
            end else if (cnt_reg != STABLE_MAX) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------ acceptance
    logic [6:0]            samp_seg;
    logic [NUM_DIGITS-1:0] samp_sel;
    logic                  one_hot;
    logic                  accept;

    assign samp_seg = sync_reg[SW-1:NUM_DIGITS];
    assign samp_sel = sync_reg[NUM_DIGITS-1:0];
    assign one_hot  = (samp_sel != '0) &&
                      ((samp_sel & (samp_sel - NUM_DIGITS'(1))) == '0);
    // Saturation stops the counter after STABLE_CYCLES. This gives exactly
    // one acceptance per stable run.
    assign accept   = same && (cnt_reg == ACCEPT_AT) && one_hot &&
                      (samp_seg != 7'h7F);

    // Returns {illegal, nibble}. An unknown glyph decodes as nibble 0 with
    // the error flag set.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [4:0] decoded;
    assign decoded = decode_glyph(samp_seg);

    // ------------------------------------------------------- capture slots
    logic [3:0]              slot_nib [NUM_DIGITS];
    logic                    slot_err [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   seen_reg;
    logic [4*NUM_DIGITS-1:0] slot_word;
    logic [NUM_DIGITS-1:0]   slot_errs;
    logic                    seen_clear;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_nib[gi] <= '0;
                    slot_err[gi] <= 1'b0;
                end else if (accept && samp_sel[gi]) begin
                    slot_nib[gi] <= decoded[3:0];
                    slot_err[gi] <= decoded[4];
                end
            end

            // A fresh acceptance on the clearing edge belongs to the next
            // scan, so setting takes priority over clearing.
            always_ff @(posedge clk) begin
                if (rst) begin
                    seen_reg[gi] <= 1'b0;
                end else if (accept && samp_sel[gi]) begin
                    seen_reg[gi] <= 1'b1;
                end else if (seen_clear) begin
                    seen_reg[gi] <= 1'b0;
                end
            end

            assign slot_word[4*gi +: 4] = slot_nib[gi];
            assign slot_errs[gi]        = slot_err[gi];
        end
    endgenerate

    // ------------------------------------------------------------ handshake
    logic [0:0]              state_reg, state_next;
    logic [4*NUM_DIGITS-1:0] word_reg;
    logic [NUM_DIGITS-1:0]   err_reg;
    logic                    valid_reg, valid_next;
    logic                    overrun_reg, overrun_next;
    logic                    load;
    logic                    all_seen;

    assign all_seen = &seen_reg;

    always_comb begin
        state_next   = state_reg;
        valid_next   = valid_reg;
        overrun_next = 1'b0;
        load         = 1'b0;
        seen_clear   = 1'b0;
        case (state_reg)
            ST_SCAN: begin
                if (all_seen) begin
                    load       = 1'b1;
                    seen_clear = 1'b1;
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            default: begin
                if (valid_reg && word_ready) begin
                    // A scan that completes in the handshake cycle moves
                    // directly into the output and is not counted as lost.
                    if (all_seen) begin
                        load       = 1'b1;
                        seen_clear = 1'b1;
                    end else begin
                        valid_next = 1'b0;
                        state_next = ST_SCAN;
                    end
                end else if (all_seen) begin
                    overrun_next = 1'b1;
                    seen_clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_SCAN;
            word_reg    <= '0;
            err_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            if (load) begin
                word_reg <= slot_word;
                err_reg  <= slot_errs;
            end
        end
    end

    assign word_out   = word_reg;
    assign digit_err  = err_reg;
    assign word_valid = valid_reg;
    assign overrun    = overrun_reg;

endmodule
